game_flow_controller: RTL and testbench
=======================================

Name: game_flow_controller

Overview:
- Frame-synchronous game sequencer sitting between the USB keycode path, the ball/obstacle motion blocks and the color mapper.
- Consumes collision and finish-line flags from the color mapper.
- Tracks lives and level, issues player respawn pulses, and drives the foreground/background palette inputs and the obstacle speed selection.
- All state updates are qualified by a one-cycle frame tick, so game timing is counted in frames.

Parameters:
- LIVES_INIT, 3: lives loaded on game start (1..7).
- MAX_LEVEL, 4: last level; clearing it ends the game in WIN (1..15).
- HIT_FRAMES, 60: frames the game freezes after a hit.
- CLEAR_FRAMES, 90: frames spent in LEVEL_CLEAR before the next level starts.
- START_KEY, 8'h2C: USB HID keycode (space) that starts or restarts the game.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-Clk pulse per video frame (vsync rising edge, already synchronised).
- keycode  in  8  current USB keycode.
- collision  in  1  player/obstacle-1 overlap (level).
- collision2  in  1  player/obstacle-2 overlap (level); only bit 0 of the mapper's 4-bit output is connected.
- finish_line_reached  in  1  player past finish line (level).
- state  out  3  encoded FSM state: IDLE=0, PLAY=1, HIT=2, LEVEL_CLEAR=3, GAME_OVER=4, WIN=5.
- lives  out  3  remaining lives.
- level  out  4  current level, 1-based.
- reset_player  out  1  one-Clk pulse; ball returns to its start position.
- motion_en  out  1  high only in PLAY; gates ball and obstacle motion.
- obs_speed  out  4  obstacle step per frame = level (saturates at MAX_LEVEL).
- foreground  out  4  palette offset to the color mapper.
- background  out  4  palette offset to the color mapper.

Behaviour:
- Reset (sampled on Clk rising edge):
  - state=IDLE, lives=LIVES_INIT, level=1, timer=0.
  - reset_player=0, motion_en=0, foreground=0, background=0.
  - A Reset asserted in any state, including mid-freeze, returns to these values on the next edge. No pulse is emitted on that edge.
- Evaluation rule: transitions below are evaluated only on cycles with frame_tick=1, except START_KEY detection. key_seen is a sticky flag set on any cycle where keycode==START_KEY and cleared when consumed.
- hit = collision | collision2, each registered once per frame_tick.
- IDLE:
  - On frame_tick with key_seen: lives=LIVES_INIT, level=1, pulse reset_player, go to PLAY.
- PLAY:
  - If hit: lives decrements by 1, timer=HIT_FRAMES, go to HIT.
  - Else if finish_line_reached: timer=CLEAR_FRAMES, go to LEVEL_CLEAR.
  - Simultaneous hit and finish: hit wins.
- HIT:
  - Timer decrements each frame_tick.
  - At timer==1: if lives==0 go to GAME_OVER; else pulse reset_player and go to PLAY.
  - Collisions are ignored while in HIT.
- LEVEL_CLEAR:
  - Timer decrements each frame_tick.
  - At timer==1: if level==MAX_LEVEL go to WIN; else level+1, pulse reset_player, go to PLAY.
- GAME_OVER / WIN:
  - On frame_tick with key_seen: behave as from IDLE (restart at level 1).
- Timer: 8 bits; a frame_tick while the timer is 0 does not wrap it.
- Lives:
  - Never decrements below 0.
  - Reaching 0 on a hit still passes through HIT for the full freeze before GAME_OVER.
- reset_player:
  - Registered, exactly one Clk wide, asserted in the Clk cycle following the transitioning frame_tick.
- Palette outputs (registered, same cycle as the state change):
  - background = level in PLAY and HIT, 4'hF in GAME_OVER, 4'h8 in WIN, 0 in IDLE.
  - In HIT, foreground toggles between 0 and 4'hF every 8 frames (foreground = timer[3] ? 4'hF : 0); 0 in all other states.
- Latency:
  - A flag present on a frame_tick cycle is reflected in state one Clk later.
  - motion_en is combinational from state.

Optional Feature:
- Macro: GAME_FLOW_INVULN_EN.
- Defined: after each respawn from HIT, a 6-bit grace counter loads 32. While it is nonzero, hits in PLAY are ignored; the counter decrements on each frame_tick. finish_line_reached still advances the level during grace.
- Undefined: no grace counter; a hit on the first PLAY frame after respawn is taken immediately.

Test Plan:
- Reset held 2 cycles, keycode=8'h2C, then frame_tick -> state 0->1, reset_player pulses once, lives=3, level=1, background=1.
- In PLAY, collision=1 on one frame_tick -> state=2, lives=2. After 60 frame_ticks -> state=1 with one reset_player pulse. foreground toggles every 8 frames during the freeze.
- collision2=1 and finish_line_reached=1 on the same frame_tick -> HIT taken, level unchanged at 1, lives decremented.
- Three successive hits -> after the third freeze state=4 (GAME_OVER), lives=0, background=F. Then START_KEY -> state=1, lives=3, level=1.
- finish_line_reached four times with MAX_LEVEL=4 -> level goes 1,2,3,4, obs_speed tracks level, then state=5 (WIN), background=8.
- Reset asserted during HIT with timer=30 -> next edge state=0, lives=3, no reset_player pulse. With GAME_FLOW_INVULN_EN defined, a hit within 32 frames of respawn does not change lives.

Source files
------------

// File: rtl/game_flow_controller_if.sv
// Signal bundle between the game sequencer and its keycode, motion and color-mapper neighbours.
// Master drives the per-frame inputs; slave (the sequencer) drives game state and palette.
interface game_flow_controller_if;
  logic       frame_tick;
  logic [7:0] keycode;
  logic       collision;
  logic       collision2;
  logic       finish_line_reached;
  logic [2:0] state;
  logic [2:0] lives;
  logic [3:0] level;
  logic       reset_player;
  logic       motion_en;
  logic [3:0] obs_speed;
  logic [3:0] foreground;
  logic [3:0] background;

  modport master (
    output frame_tick, keycode, collision, collision2, finish_line_reached,
    input  state, lives, level, reset_player, motion_en, obs_speed, foreground, background
  );

  modport slave (
    input  frame_tick, keycode, collision, collision2, finish_line_reached,
    output state, lives, level, reset_player, motion_en, obs_speed, foreground, background
  );
endinterface

// File: rtl/game_flow_controller.sv
// Frame-synchronous game sequencer: lives, level, hit freeze, level clear, palette and speed select.
// Latency: flags on a frame_tick cycle show in state/palette/reset_player one Clk later; motion_en is comb.
// No backpressure; GAME_FLOW_INVULN_EN adds a 32-frame post-respawn grace period.
module game_flow_controller #(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned MAX_LEVEL    = 4,
  parameter int unsigned HIT_FRAMES   = 60,
  parameter int unsigned CLEAR_FRAMES = 90,
  parameter logic [7:0]  START_KEY    = 8'h2C
) (
  input  logic                  Clk,
  input  logic                  Reset,
  game_flow_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_HIT   = 3'd2,
    S_CLEAR = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_e;

  localparam logic [2:0] LIVES_RST  = 3'(LIVES_INIT);
  localparam logic [3:0] MAX_LVL    = 4'(MAX_LEVEL);
  localparam logic [7:0] HIT_LOAD   = 8'(HIT_FRAMES);
  localparam logic [7:0] CLEAR_LOAD = 8'(CLEAR_FRAMES);

  state_e     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [3:0] level_q, level_d;
  logic [7:0] timer_q, timer_d;
  logic       key_seen_q, key_seen_d;
  logic       reset_player_q, reset_player_d;
  logic [3:0] fg_q, fg_d;
  logic [3:0] bg_q, bg_d;
  logic       key_now, start_req, hit, hit_eff, timer_last, consume;
`ifdef GAME_FLOW_INVULN_EN
  logic [5:0] grace_q, grace_d;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      lives_q        <= LIVES_RST;
      level_q        <= 4'd1;
      timer_q        <= 8'd0;
      key_seen_q     <= 1'b0;
      reset_player_q <= 1'b0;
      fg_q           <= 4'd0;
      bg_q           <= 4'd0;
`ifdef GAME_FLOW_INVULN_EN
      grace_q        <= 6'd0;
`endif
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      level_q        <= level_d;
      timer_q        <= timer_d;
      key_seen_q     <= key_seen_d;
      reset_player_q <= reset_player_d;
      fg_q           <= fg_d;
      bg_q           <= bg_d;
`ifdef GAME_FLOW_INVULN_EN
      grace_q        <= grace_d;
`endif
    end
  end

  always_comb begin
    key_now        = (bus.keycode == START_KEY);
    start_req      = key_seen_q | key_now;
    hit            = bus.collision | bus.collision2;
    timer_last     = (timer_q <= 8'd1);
    state_d        = state_q;
    lives_d        = lives_q;
    level_d        = level_q;
    timer_d        = timer_q;
    reset_player_d = 1'b0;
    consume        = 1'b0;
`ifdef GAME_FLOW_INVULN_EN
    grace_d        = grace_q;
    hit_eff        = hit & (grace_q == 6'd0);
`else
    hit_eff        = hit;
`endif

    if (bus.frame_tick) begin
`ifdef GAME_FLOW_INVULN_EN
      if (grace_q != 6'd0) grace_d = grace_q - 6'd1;
`endif
      case (state_q)
        S_IDLE, S_OVER, S_WIN: begin
          if (start_req) begin
            lives_d        = LIVES_RST;
            level_d        = 4'd1;
            reset_player_d = 1'b1;
            consume        = 1'b1;
            state_d        = S_PLAY;
          end
        end
        S_PLAY: begin
          // A hit outranks a finish crossing on the same frame.
          if (hit_eff) begin
            lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
            timer_d = HIT_LOAD;
            state_d = S_HIT;
          end else if (bus.finish_line_reached) begin
            timer_d = CLEAR_LOAD;
            state_d = S_CLEAR;
          end
        end
        S_HIT: begin
          if (timer_q != 8'd0) timer_d = timer_q - 8'd1;
          if (timer_last) begin
            if (lives_q == 3'd0) begin
              state_d = S_OVER;
            end else begin
              reset_player_d = 1'b1;
              state_d        = S_PLAY;
`ifdef GAME_FLOW_INVULN_EN
              grace_d        = 6'd32;
`endif
            end
          end
        end
        S_CLEAR: begin
          if (timer_q != 8'd0) timer_d = timer_q - 8'd1;
          if (timer_last) begin
            if (level_q >= MAX_LVL) begin
              state_d = S_WIN;
            end else begin
              level_d        = level_q + 4'd1;
              reset_player_d = 1'b1;
              state_d        = S_PLAY;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    key_seen_d = consume ? 1'b0 : (key_seen_q | key_now);

    // Palette follows the next state so it changes on the same edge as state.
    fg_d = ((state_d == S_HIT) && timer_d[3]) ? 4'hF : 4'h0;
    case (state_d)
      S_PLAY, S_HIT, S_CLEAR: bg_d = level_d;
      S_OVER:                 bg_d = 4'hF;
      S_WIN:                  bg_d = 4'h8;
      default:                bg_d = 4'h0;
    endcase
  end

  assign bus.state        = state_q;
  assign bus.lives        = lives_q;
  assign bus.level        = level_q;
  assign bus.reset_player = reset_player_q;
  assign bus.motion_en    = (state_q == S_PLAY);
  assign bus.obs_speed    = (level_q > MAX_LVL) ? MAX_LVL : level_q;
  assign bus.foreground   = fg_q;
  assign bus.background   = bg_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: vector table, directed corner sequences, then random play
// checked cycle by cycle against a frame-counting game model.
module tb_game_flow_controller;
  localparam int LIVES_INIT   = 3;
  localparam int MAX_LEVEL    = 4;
  localparam int HIT_FRAMES   = 60;
  localparam int CLEAR_FRAMES = 90;
  localparam logic [7:0] START_KEY = 8'h2C;
  localparam int M_IDLE = 0, M_PLAY = 1, M_HIT = 2, M_CLEAR = 3, M_OVER = 4, M_WIN = 5;

  logic clk = 1'b0;
  logic rst;
  game_flow_controller_if gif();

  game_flow_controller #(
    .LIVES_INIT(LIVES_INIT), .MAX_LEVEL(MAX_LEVEL), .HIT_FRAMES(HIT_FRAMES),
    .CLEAR_FRAMES(CLEAR_FRAMES), .START_KEY(START_KEY)
  ) dut (
    .Clk(clk),
    .Reset(rst),
    .bus(gif.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Game model: mode, lives, level, frames left in the current freeze, grace frames left.
  int m_mode = M_IDLE, m_lives = LIVES_INIT, m_level = 1, m_left = 0, m_grace = 0;
  bit m_key = 1'b0, m_pulse = 1'b0;

  typedef struct {
    bit r; bit t; logic [7:0] k; bit c1; bit c2; bit f;
    int st; int lv; int lvl; int rp; int bg;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_step(input bit r, input bit t, input logic [7:0] k,
                            input bit c1, input bit c2, input bit f);
    bit want_start;
    bit shielded;
    m_pulse = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_lives = LIVES_INIT; m_level = 1; m_left = 0; m_key = 1'b0; m_grace = 0;
      return;
    end
    want_start = m_key || (k == START_KEY);
    if (k == START_KEY) m_key = 1'b1;
    if (!t) return;
    shielded = 1'b0;
`ifdef GAME_FLOW_INVULN_EN
    shielded = (m_grace > 0);
    if (m_grace > 0) m_grace--;
`endif
    case (m_mode)
      M_IDLE, M_OVER, M_WIN: if (want_start) begin
        m_key = 1'b0; m_mode = M_PLAY; m_lives = LIVES_INIT; m_level = 1; m_pulse = 1'b1;
      end
      M_PLAY: if ((c1 || c2) && !shielded) begin
        m_lives = (m_lives > 0) ? m_lives - 1 : 0; m_left = HIT_FRAMES; m_mode = M_HIT;
      end else if (f) begin
        m_left = CLEAR_FRAMES; m_mode = M_CLEAR;
      end
      M_HIT: begin
        m_left--;
        if (m_left == 0) begin
          if (m_lives == 0) m_mode = M_OVER;
          else begin m_mode = M_PLAY; m_pulse = 1'b1; m_grace = 32; end
        end
      end
      M_CLEAR: begin
        m_left--;
        if (m_left == 0) begin
          if (m_level == MAX_LEVEL) m_mode = M_WIN;
          else begin m_level++; m_mode = M_PLAY; m_pulse = 1'b1; end
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  function automatic int exp_bg();
    case (m_mode)
      M_PLAY, M_HIT, M_CLEAR: return m_level;
      M_OVER:                 return 15;
      M_WIN:                  return 8;
      default:                return 0;
    endcase
  endfunction

  task automatic compare_all();
    check("state", gif.state, m_mode);
    check("lives", gif.lives, m_lives);
    check("level", gif.level, m_level);
    check("reset_player", gif.reset_player, m_pulse);
    check("motion_en", gif.motion_en, (m_mode == M_PLAY) ? 1 : 0);
    check("obs_speed", gif.obs_speed, (m_level < MAX_LEVEL) ? m_level : MAX_LEVEL);
    check("foreground", gif.foreground, (m_mode == M_HIT && ((m_left / 8) % 2 == 1)) ? 15 : 0);
    check("background", gif.background, exp_bg());
  endtask

  task automatic cycle(input bit r, input bit t, input logic [7:0] k,
                       input bit c1, input bit c2, input bit f);
    @(negedge clk);
    rst = r; gif.frame_tick = t; gif.keycode = k;
    gif.collision = c1; gif.collision2 = c2; gif.finish_line_reached = f;
    @(posedge clk);
    model_step(r, t, k, c1, c2, f);
    #1;
    compare_all();
  endtask

  task automatic frame(input bit c1, input bit c2, input bit f);
    cycle(1'b0, 1'b1, 8'h00, c1, c2, f);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int toggles, pulses;
    logic [3:0] prev_fg;
    rst = 1'b1; gif.frame_tick = 1'b0; gif.keycode = 8'h00;
    gif.collision = 1'b0; gif.collision2 = 1'b0; gif.finish_line_reached = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 8'h2C, 1'b0, 1'b0, 1'b0, 0, 3, 1, 0, 0};
    vecs[1] = '{1'b1, 1'b1, 8'h2C, 1'b0, 1'b0, 1'b0, 0, 3, 1, 0, 0};
    vecs[2] = '{1'b0, 1'b0, 8'h2C, 1'b0, 1'b0, 1'b0, 0, 3, 1, 0, 0};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1, 3, 1, 1, 1};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 3, 1, 0, 1};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2, 2, 1, 0, 1};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2, 2, 1, 0, 1};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2, 2, 1, 0, 1};
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].r, vecs[i].t, vecs[i].k, vecs[i].c1, vecs[i].c2, vecs[i].f);
      check("vec_state", gif.state, vecs[i].st);
      check("vec_lives", gif.lives, vecs[i].lv);
      check("vec_level", gif.level, vecs[i].lvl);
      check("vec_reset_player", gif.reset_player, vecs[i].rp);
      check("vec_background", gif.background, vecs[i].bg);
    end

    // Remainder of the first freeze: foreground toggles every 8 frames, one respawn pulse.
    toggles = 0; pulses = 0; prev_fg = gif.foreground;
    for (int i = 0; i < HIT_FRAMES - 1; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      if (gif.foreground != prev_fg) toggles++;
      prev_fg = gif.foreground;
      pulses += int'(gif.reset_player);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      pulses += int'(gif.reset_player);
    end
    check("freeze_fg_toggles", toggles, 7);
    check("freeze_respawn_pulses", pulses, 1);
    check("after_freeze_state", gif.state, 1);
    check("after_freeze_lives", gif.lives, 2);

    // Hit and finish on the same frame: hit wins.
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
    check("hit_vs_finish_state", gif.state, 2);
    check("hit_vs_finish_level", gif.level, 1);
    check("hit_vs_finish_lives", gif.lives, 1);
    repeat (HIT_FRAMES) frame(1'b0, 1'b0, 1'b0);
    check("second_respawn_state", gif.state, 1);

    // Last life: full freeze, then game over; restart with the start key.
    frame(1'b1, 1'b0, 1'b0);
    check("last_hit_state", gif.state, 2);
    check("last_hit_lives", gif.lives, 0);
    repeat (HIT_FRAMES) frame(1'b0, 1'b0, 1'b0);
    check("game_over_state", gif.state, 4);
    check("game_over_bg", gif.background, 15);
    cycle(1'b0, 1'b0, START_KEY, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
    check("restart_state", gif.state, 1);
    check("restart_lives", gif.lives, 3);
    check("restart_level", gif.level, 1);

    // Four level clears lead to WIN.
    for (int lvl = 1; lvl <= MAX_LEVEL; lvl++) begin
      check("level_progress", gif.level, lvl);
      check("obs_speed_progress", gif.obs_speed, lvl);
      frame(1'b0, 1'b0, 1'b1);
      check("clear_state", gif.state, 3);
      repeat (CLEAR_FRAMES) frame(1'b0, 1'b0, 1'b0);
    end
    check("win_state", gif.state, 5);
    check("win_bg", gif.background, 8);

    // Reset in the middle of a freeze.
    cycle(1'b0, 1'b0, START_KEY, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0);
    repeat (30) frame(1'b0, 1'b0, 1'b0);
    check("mid_freeze_state", gif.state, 2);
    cycle(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    check("reset_mid_freeze_state", gif.state, 0);
    check("reset_mid_freeze_lives", gif.lives, 3);
    check("reset_mid_freeze_pulse", gif.reset_player, 0);
    check("reset_mid_freeze_fg", gif.foreground, 0);

    // Hit on the first frame after a respawn.
    cycle(1'b0, 1'b0, START_KEY, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0);
    repeat (HIT_FRAMES) frame(1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0);
`ifdef GAME_FLOW_INVULN_EN
    check("grace_hit_state", gif.state, 1);
    check("grace_hit_lives", gif.lives, 2);
`else
    check("respawn_hit_state", gif.state, 2);
    check("respawn_hit_lives", gif.lives, 1);
`endif

    // Random play against the model.
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6000; i++) begin
      logic [7:0] k;
      k = ($urandom % 30 == 0) ? START_KEY : 8'($urandom % 256);
      cycle(($urandom % 700) == 0, ($urandom % 3) == 0, k,
            ($urandom % 15) == 0, ($urandom % 15) == 0, ($urandom % 25) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
